// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, buffered entry layout
// and the fixed instruction width in bytes.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs; head is visible
// combinationally, flush empties it in one edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    // Guards here keep the FIFO safe even if a caller asks for an illegal op.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: sequential PC generation, redirect handling and
// a small decoupling buffer toward decode.
//
//   state | meaning
//   IDLE  | no new fetches; buffered entries still drain to decode
//   FETCH | one word fetched per edge whenever a buffer slot is free
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          push;
    logic          pop;

    assign if_valid = (count != '0);
    assign pop      = if_valid && if_ready;
    assign push     = (state_q == FETCH) && !redirect_valid &&
                      ((count != CW'(BUF_DEPTH)) || pop);

    assign push_data.pc    = fetch_pc_q;
    assign push_data.instr = imem_instr;

    always_comb begin
        state_d    = fetch_en ? FETCH : IDLE;
        fetch_pc_d = fetch_pc_q;
        // Redirect targets are word-aligned by dropping the low two bits.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h0000_0003;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign imem_addr = fetch_pc_q;
    assign if_instr  = if_valid ? head.instr : 32'h0;
    assign if_pc     = if_valid ? head.pc    : 32'h0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table for start-up,
// backpressure and redirect, then hand sequences for drain, wrap and reset.
module tb_instr_fetch;

    logic        clk;
    logic        rstn;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h8020_000A;
            32'h0000_0004: mem_word = 32'h0440_0800;
            32'h0000_0008: mem_word = 32'h0C60_0800;
            default:       mem_word = {a[15:0], 16'hC0DE};
        endcase
    endfunction

    always_comb imem_instr = mem_word(imem_addr);

    typedef struct {
        logic        rstn;
        logic        fen;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tv [22];

    function automatic vec_t mk(input logic r, input logic f, input logic v,
                                input logic [31:0] p, input logic y,
                                input logic ev, input logic [31:0] epc,
                                input logic [31:0] ei, input logic [31:0] ea);
        vec_t t;
        t.rstn = r; t.fen = f; t.rv = v; t.rpc = p; t.rdy = y;
        t.ev = ev; t.epc = epc; t.einstr = ei; t.eaddr = ea;
        return t;
    endfunction

    // Drive at the falling edge; outputs are then stable until the next rising edge.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] p, input logic y);
        @(negedge clk);
        rstn           = r;
        fetch_en       = f;
        redirect_valid = v;
        redirect_pc    = p;
        if_ready       = y;
        #1;
    endtask

    task automatic chk(input string name, input logic ev, input logic [31:0] epc,
                       input logic [31:0] ei, input logic [31:0] ea);
        n_vec++;
        if (if_valid !== ev || if_pc !== epc || if_instr !== ei || imem_addr !== ea) begin
            n_err++;
            $display("FAIL %s: got valid=%0b pc=%h instr=%h addr=%h, want valid=%0b pc=%h instr=%h addr=%h",
                     name, if_valid, if_pc, if_instr, imem_addr, ev, epc, ei, ea);
        end
    endtask

    initial begin
        rstn           = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;

        // Row outputs are the state left by the edges of all earlier rows.
        tv[0]  = mk(0,1,0,32'h0,1, 0,32'h0,32'h0,32'h0);
        tv[1]  = mk(0,1,0,32'h0,1, 0,32'h0,32'h0,32'h0);
        tv[2]  = mk(1,1,0,32'h0,1, 0,32'h0,32'h0,32'h0);
        tv[3]  = mk(1,1,0,32'h0,1, 0,32'h0,32'h0,32'h0);
        tv[4]  = mk(1,1,0,32'h0,1, 1,32'h0,32'h8020_000A,32'h4);
        tv[5]  = mk(1,1,0,32'h0,1, 1,32'h4,32'h0440_0800,32'h8);
        tv[6]  = mk(1,1,0,32'h0,1, 1,32'h8,32'h0C60_0800,32'hC);
        tv[7]  = mk(0,1,0,32'h0,0, 1,32'hC,32'h000C_C0DE,32'h10);
        tv[8]  = mk(1,1,0,32'h0,0, 0,32'h0,32'h0,32'h0);
        tv[9]  = mk(1,1,0,32'h0,0, 0,32'h0,32'h0,32'h0);
        tv[10] = mk(1,1,0,32'h0,0, 1,32'h0,32'h8020_000A,32'h4);
        tv[11] = mk(1,1,0,32'h0,0, 1,32'h0,32'h8020_000A,32'h8);
        tv[12] = mk(1,1,0,32'h0,0, 1,32'h0,32'h8020_000A,32'h8);
        tv[13] = mk(1,1,0,32'h0,0, 1,32'h0,32'h8020_000A,32'h8);
        tv[14] = mk(1,1,0,32'h0,0, 1,32'h0,32'h8020_000A,32'h8);
        tv[15] = mk(1,1,0,32'h0,1, 1,32'h0,32'h8020_000A,32'h8);
        tv[16] = mk(1,1,0,32'h0,1, 1,32'h4,32'h0440_0800,32'hC);
        tv[17] = mk(1,1,0,32'h0,0, 1,32'h8,32'h0C60_0800,32'h10);
        tv[18] = mk(1,1,1,32'h6,0, 1,32'h8,32'h0C60_0800,32'h10);
        tv[19] = mk(1,1,0,32'h0,1, 0,32'h0,32'h0,32'h4);
        tv[20] = mk(1,1,0,32'h0,1, 1,32'h4,32'h0440_0800,32'h8);
        tv[21] = mk(1,1,0,32'h0,1, 1,32'h8,32'h0C60_0800,32'hC);

        for (int i = 0; i < 22; i++) begin
            step(tv[i].rstn, tv[i].fen, tv[i].rv, tv[i].rpc, tv[i].rdy);
            chk($sformatf("vec%0d", i), tv[i].ev, tv[i].epc, tv[i].einstr, tv[i].eaddr);
        end

        // Drain: fill both slots, drop fetch_en under stall, then release.
        step(0,1,0,32'h0,0);
        step(1,1,0,32'h0,0);
        step(1,1,0,32'h0,0);
        step(1,1,0,32'h0,0);
        step(1,0,0,32'h0,0);
        chk("drain_full", 1, 32'h0, 32'h8020_000A, 32'h8);
        step(1,0,0,32'h0,1);
        chk("drain_head0", 1, 32'h0, 32'h8020_000A, 32'h8);
        step(1,0,0,32'h0,1);
        chk("drain_head1", 1, 32'h4, 32'h0440_0800, 32'h8);
        for (int k = 0; k < 4; k++) begin
            step(1,0,0,32'h0,1);
            chk($sformatf("drain_empty%0d", k), 0, 32'h0, 32'h0, 32'h8);
        end

        // Redirect to the last word of the address space, then wrap to zero.
        step(1,1,1,32'hFFFF_FFFC,1);
        chk("wrap_pre", 0, 32'h0, 32'h0, 32'h8);
        step(1,1,0,32'h0,1);
        chk("wrap_addr", 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        step(1,1,0,32'h0,1);
        chk("wrap_top", 1, 32'hFFFF_FFFC, 32'hFFFC_C0DE, 32'h0);
        step(1,1,0,32'h0,1);
        chk("wrap_zero", 1, 32'h0, 32'h8020_000A, 32'h4);

        // Reset asserted together with a redirect mid-stream.
        step(0,1,1,32'h40,1);
        chk("rst_pre", 1, 32'h4, 32'h0440_0800, 32'h8);
        step(1,1,0,32'h0,1);
        chk("rst_redir", 0, 32'h0, 32'h0, 32'h0);

        // Redirect coinciding with a pop: the popped entry is simply gone.
        step(1,1,0,32'h0,1);
        chk("popredir_a", 0, 32'h0, 32'h0, 32'h0);
        step(1,1,0,32'h0,1);
        chk("popredir_b", 1, 32'h0, 32'h8020_000A, 32'h4);
        step(1,1,1,32'hB,1);
        chk("popredir_c", 1, 32'h4, 32'h0440_0800, 32'h8);
        step(1,1,0,32'h0,1);
        chk("popredir_d", 0, 32'h0, 32'h0, 32'h8);
        step(1,1,0,32'h0,1);
        chk("popredir_e", 1, 32'h8, 32'h0C60_0800, 32'hC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
